// File: rtl/param_fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO family.
package param_fifo_pkg;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int fifo_ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Signal bundle for param_sync_fifo; rtl side drives status, tb side drives requests.
interface param_sync_fifo_if #(
    parameter int DATA_BITS  = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input logic clk
);
    logic                  reset;
    logic [DATA_BITS-1:0]  input_data;
    logic                  write;
    logic                  read;
    logic                  clear_err;
    logic [DATA_BITS-1:0]  output_data;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport rtl (
        input  clk, reset, input_data, write, read, clear_err,
        output output_data, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport tb (
        input  clk, output_data, empty, full, almost_empty, almost_full, count, overflow, underflow,
        output reset, input_data, write, read, clear_err
    );
endinterface

// File: rtl/fifo_regfile.sv
// FIFO storage array: synchronous write, asynchronous read, contents never reset.
module fifo_regfile #(
    parameter int DATA_BITS  = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_BITS-1:0]  rd_data
);
    logic [DATA_BITS-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with optional first-word-fall-through output,
// programmable almost-full/almost-empty levels, occupancy count and sticky error flags.
module param_sync_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_BITS  = 10,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_BITS-1:0]  input_data,
    input  logic                  write,
    input  logic                  read,
    input  logic                  clear_err,
    output logic [DATA_BITS-1:0]  output_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int PTR_W = fifo_ptr_w(DEPTH_LOG2);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 10) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH_LOG2 must be in 1..10");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("param_sync_fifo: FWFT must be 0 or 1");
    end

    logic [PTR_W-1:0]     wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_d, rd_ptr_q;
    logic                 overflow_d, overflow_q;
    logic                 underflow_d, underflow_q;
    logic                 wr_acc, rd_acc;
    logic [DATA_BITS-1:0] rd_data;

    // Status decode straight from the registered pointers.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                          (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Handshake: a write is taken on any edge where write && !full, a read where
    // read && !empty; rejected requests only raise the sticky error flags.
    assign wr_acc = write && !full;
    assign rd_acc = read && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // A fresh error wins over a simultaneous clear.
        overflow_d  = (write && full)  || (overflow_q  && !clear_err);
        underflow_d = (read  && empty) || (underflow_q && !clear_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_regfile #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[PTR_W-2:0]),
        .wr_data (input_data),
        .rd_addr (rd_ptr_q[PTR_W-2:0]),
        .rd_data (rd_data)
    );

    if (MODE == FIFO_MODE_STD) begin : g_std
        logic [DATA_BITS-1:0] dout_d, dout_q;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) dout_d = rd_data;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) dout_q <= '0;
            else        dout_q <= dout_d;
        end

        assign output_data = dout_q;
    end else begin : g_fwft
        // Head of queue is presented continuously; meaningless while empty.
        assign output_data = rd_data;
    end
endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a standard-mode and an FWFT instance see identical
// stimulus and are both compared against one queue-based reference model.
module tb_param_sync_fifo;
    localparam int DW    = 10;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_BITS(DW), .DEPTH_LOG2(DL2)) s_if (.clk(clk));
    param_sync_fifo_if #(.DATA_BITS(DW), .DEPTH_LOG2(DL2)) f_if (.clk(clk));

    param_sync_fifo #(
        .DATA_BITS(DW), .DEPTH_LOG2(DL2), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) u_std (
        .clk          (clk),
        .reset        (s_if.reset),
        .input_data   (s_if.input_data),
        .write        (s_if.write),
        .read         (s_if.read),
        .clear_err    (s_if.clear_err),
        .output_data  (s_if.output_data),
        .empty        (s_if.empty),
        .full         (s_if.full),
        .almost_empty (s_if.almost_empty),
        .almost_full  (s_if.almost_full),
        .count        (s_if.count),
        .overflow     (s_if.overflow),
        .underflow    (s_if.underflow)
    );

    param_sync_fifo #(
        .DATA_BITS(DW), .DEPTH_LOG2(DL2), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) u_fwft (
        .clk          (clk),
        .reset        (f_if.reset),
        .input_data   (f_if.input_data),
        .write        (f_if.write),
        .read         (f_if.read),
        .clear_err    (f_if.clear_err),
        .output_data  (f_if.output_data),
        .empty        (f_if.empty),
        .full         (f_if.full),
        .almost_empty (f_if.almost_empty),
        .almost_full  (f_if.almost_full),
        .count        (f_if.count),
        .overflow     (f_if.overflow),
        .underflow    (f_if.underflow)
    );

    // Reference model and scoreboard
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_out;
    bit            exp_ovf;
    bit            exp_unf;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_out = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, " std.count"},     32'(s_if.count),       32'(n));
        chk({tag, " std.empty"},     32'(s_if.empty),       32'(n == 0));
        chk({tag, " std.full"},      32'(s_if.full),        32'(n == DEPTH));
        chk({tag, " std.ae"},        32'(s_if.almost_empty), 32'(n <= AE));
        chk({tag, " std.af"},        32'(s_if.almost_full), 32'(n >= AF));
        chk({tag, " std.overflow"},  32'(s_if.overflow),    32'(exp_ovf));
        chk({tag, " std.underflow"}, 32'(s_if.underflow),   32'(exp_unf));
        chk({tag, " std.dout"},      32'(s_if.output_data), 32'(exp_out));
        chk({tag, " fwft.count"},    32'(f_if.count),       32'(n));
        chk({tag, " fwft.empty"},    32'(f_if.empty),       32'(n == 0));
        chk({tag, " fwft.full"},     32'(f_if.full),        32'(n == DEPTH));
        chk({tag, " fwft.ae"},       32'(f_if.almost_empty), 32'(n <= AE));
        chk({tag, " fwft.af"},       32'(f_if.almost_full), 32'(n >= AF));
        chk({tag, " fwft.overflow"}, 32'(f_if.overflow),    32'(exp_ovf));
        chk({tag, " fwft.underflow"}, 32'(f_if.underflow),  32'(exp_unf));
        if (n > 0) chk({tag, " fwft.dout"}, 32'(f_if.output_data), 32'(exp_q[0]));
    endtask

    task automatic set_reset(input logic v);
        s_if.reset = v;
        f_if.reset = v;
    endtask

    // Driver: one clock cycle of requests, model updated from pre-edge occupancy.
    task automatic step(input string tag, input bit w, input bit r, input bit c,
                        input logic [DW-1:0] d);
        int  n;
        bit  is_full, is_empty;
        s_if.write = w; s_if.read = r; s_if.clear_err = c; s_if.input_data = d;
        f_if.write = w; f_if.read = r; f_if.clear_err = c; f_if.input_data = d;
        n        = exp_q.size();
        is_full  = (n == DEPTH);
        is_empty = (n == 0);
        exp_ovf  = (w && is_full)  || (exp_ovf && !c);
        exp_unf  = (r && is_empty) || (exp_unf && !c);
        if (r && !is_empty) exp_out = exp_q.pop_front();
        if (w && !is_full)  exp_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        s_if.write = 1'b0; s_if.read = 1'b0; s_if.clear_err = 1'b0;
        f_if.write = 1'b0; f_if.read = 1'b0; f_if.clear_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] d;
        s_if.write = 1'b0; s_if.read = 1'b0; s_if.clear_err = 1'b0; s_if.input_data = '0;
        f_if.write = 1'b0; f_if.read = 1'b0; f_if.clear_err = 1'b0; f_if.input_data = '0;
        set_reset(1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        set_reset(1'b1);

        // Fill from empty, then a dropped write
        for (int i = 1; i <= 4; i++) step("fill", 1'b1, 1'b0, 1'b0, DW'(i));
        step("fill_overflow", 1'b1, 1'b0, 1'b0, 10'h3FF);

        // Drain, then a read from empty
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 1'b0, '0);
        chk("drain last std.dout", 32'(s_if.output_data), 32'h004);
        step("drain_underflow", 1'b0, 1'b1, 1'b0, '0);
        chk("underflow hold std.dout", 32'(s_if.output_data), 32'h004);
        step("clear_both", 1'b0, 1'b0, 1'b1, '0);

        // FWFT fall-through without a read
        step("fwft_write", 1'b1, 1'b0, 1'b0, 10'h2AA);
        chk("fwft fallthrough dout", 32'(f_if.output_data), 32'h2AA);
        step("fwft_read", 1'b0, 1'b1, 1'b0, '0);
        chk("fwft read empty", 32'(f_if.empty), 32'd1);

        // Wrap-around at steady occupancy 2
        step("wrap_pre", 1'b1, 1'b0, 1'b0, 10'h010);
        step("wrap_pre", 1'b1, 1'b0, 1'b0, 10'h011);
        for (int i = 0; i < 10; i++) step("wrap", 1'b1, 1'b1, 1'b0, DW'(10'h012 + i));

        // Error priority: clear concurrent with a new overflow
        step("prio_fill", 1'b1, 1'b0, 1'b0, 10'h020);
        step("prio_fill", 1'b1, 1'b0, 1'b0, 10'h021);
        step("prio_ovf", 1'b1, 1'b0, 1'b0, 10'h022);
        step("prio_clr_and_ovf", 1'b1, 1'b0, 1'b1, 10'h023);
        chk("prio overflow kept", 32'(s_if.overflow), 32'd1);
        step("prio_clr", 1'b0, 1'b0, 1'b1, '0);
        chk("prio overflow cleared", 32'(s_if.overflow), 32'd0);

        // Asynchronous reset mid-cycle at count 3
        step("rst_pre", 1'b0, 1'b1, 1'b0, '0);
        chk("rst_pre count", 32'(s_if.count), 32'd3);
        #2;
        set_reset(1'b0);
        model_reset();
        #1;
        check_all("rst_mid");
        @(negedge clk);
        set_reset(1'b1);
        step("post_rst_wr", 1'b1, 1'b0, 1'b0, 10'h155);
        step("post_rst_rd", 1'b0, 1'b1, 1'b0, '0);
        chk("post reset readback", 32'(s_if.output_data), 32'h155);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            d = DW'($urandom_range(0, (1 << DW) - 1));
            step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
